data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit.sv | 176 +++++++++++++++++
 tb/tb_data_mem_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Byte-addressable data memory with load/store request/response handshake.
// Build macro DATA_MEM_MISALIGN_SPLIT_EN: misaligned accesses are split over two cycles instead of erroring.
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_err
);

`ifdef DATA_MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [31:0]       offset;
  logic [1:0]        off;
  logic [2:0]        nbytes;
  logic [3:0]        mask;
  logic [7:0]        be64;
  logic [63:0]       data64;
  logic [32:0]       last_byte;
  logic              range_err, misal, accept, hi_ok;
  logic [IDX_W-1:0]  lo_idx, hi_idx;

  logic              rsp_d, err_d, capture;
  logic [31:0]       rdata_d;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data, rd_word;

  // Second-half context held across the SPLIT cycle
  logic              sp_we, sp_uns, sp_ok;
  logic [1:0]        sp_size, sp_off;
  logic [IDX_W-1:0]  sp_idx;
  logic [3:0]        sp_be;
  logic [31:0]       sp_data, sp_lo;

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   extend = uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   extend = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign o_req_ready = (state_q == IDLE) && !i_rst;
  assign accept      = i_req_valid && o_req_ready;
  assign rd_word     = mem[rd_idx];

  // Request decode: lanes, range and alignment
  always_comb begin
    offset = i_address - BASE_ADDR;
    off    = offset[1:0];
    case (i_size)
      2'b00:   begin nbytes = 3'd1; mask = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; mask = 4'b0011; end
      2'b10:   begin nbytes = 3'd4; mask = 4'b1111; end
      default: begin nbytes = 3'd0; mask = 4'b0000; end
    endcase
    be64      = {4'b0000, mask} << off;
    data64    = {32'h0, i_wdata} << {off, 3'b000};
    last_byte = {1'b0, offset} + 33'(nbytes) - 33'd1;
    range_err = (i_address < BASE_ADDR) || (last_byte >= LIMIT);
    misal     = ((i_size == 2'b01) && i_address[0]) ||
                ((i_size == 2'b10) && (i_address[1:0] != 2'b00));
    lo_idx    = offset[IDX_W+1:2];
    hi_idx    = lo_idx + IDX_W'(1);
    hi_ok     = (32'(lo_idx) + 32'd1) < DEPTH_WORDS;
  end

  // Next state, memory port control and next response
  always_comb begin
    state_d = state_q;
    rsp_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0;
    capture = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = lo_idx;
    wr_be   = be64[3:0];
    wr_data = data64[31:0];
    rd_idx  = lo_idx;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((i_size == 2'b11) || range_err || (misal && !SPLIT_EN)) begin
            rsp_d = 1'b1;
            err_d = 1'b1;
          end else if (misal) begin
            wr_en   = i_we;
            capture = 1'b1;
            state_d = SPLIT;
          end else begin
            rsp_d = 1'b1;
            wr_en = i_we;
            if (!i_we) rdata_d = extend(rd_word >> {off, 3'b000}, i_size, i_unsigned);
          end
        end
      end
      SPLIT: begin
        state_d = IDLE;
        rd_idx  = sp_idx;
        wr_idx  = sp_idx;
        wr_be   = sp_be;
        wr_data = sp_data;
        // Reset during SPLIT drops the second-word write
        wr_en   = sp_we && sp_ok && !i_rst;
        rsp_d   = 1'b1;
        if (!sp_we)
          rdata_d = extend(32'({(sp_ok ? rd_word : 32'h0), sp_lo} >> {sp_off, 3'b000}),
                           sp_size, sp_uns);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      o_rsp_valid <= 1'b0;
      o_rdata     <= 32'h0;
      o_err       <= 1'b0;
    end else begin
      state_q     <= state_d;
      o_rsp_valid <= rsp_d;
      o_rdata     <= rdata_d;
      o_err       <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (capture) begin
      sp_we   <= i_we;
      sp_uns  <= i_unsigned;
      sp_size <= i_size;
      sp_off  <= off;
      sp_idx  <= hi_idx;
      sp_ok   <= hi_ok;
      sp_be   <= be64[7:4];
      sp_data <= data64[63:32];
      sp_lo   <= rd_word;
    end
  end

  // Storage has no reset; contents survive i_rst
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit; expectations follow DATA_MEM_MISALIGN_SPLIT_EN.
module tb_data_mem_unit;

  localparam logic [31:0] B   = 32'h0000_1000;
  localparam logic [31:0] TOP = 32'h0000_2000;

  logic        clk, i_rst, i_req_valid, o_req_ready, i_we, i_unsigned;
  logic [1:0]  i_size;
  logic [31:0] i_address, i_wdata, o_rdata;
  logic        o_rsp_valid, o_err;
  int          checks, errors;

  data_mem_unit #(.DEPTH_WORDS(1024), .BASE_ADDR(B)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_we(i_we), .i_size(i_size), .i_unsigned(i_unsigned), .i_address(i_address),
    .i_wdata(i_wdata), .o_rsp_valid(o_rsp_valid), .o_rdata(o_rdata), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge and check latency, ready dip and response
  task automatic req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                     input logic [31:0] exp_rdata, input logic exp_err);
    int   lat;
    logic rdy1;
    i_we = we; i_size = size; i_unsigned = uns; i_address = addr; i_wdata = wdata;
    i_req_valid = 1'b1;
    chk({tag, ":ready"}, 32'(o_req_ready), 32'd1);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    lat  = 0;
    rdy1 = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) rdy1 = o_req_ready;
    end while (!o_rsp_valid && lat < 4);
    chk({tag, ":lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":ready1"}, 32'(rdy1), (exp_lat == 2) ? 32'd0 : 32'd1);
    chk({tag, ":rdata"}, o_rdata, exp_rdata);
    chk({tag, ":err"}, 32'(o_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, ":pulse"}, 32'(o_rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    i_rst = 1'b1; i_req_valid = 1'b0; i_we = 1'b0; i_size = 2'b00; i_unsigned = 1'b0;
    i_address = 32'h0; i_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst:ready", 32'(o_req_ready), 32'd0);
    chk("rst:rsp", 32'(o_rsp_valid), 32'd0);
    chk("rst:rdata", o_rdata, 32'h0);
    chk("rst:err", 32'(o_err), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);

    req("sw10", 1, 2'b10, 0, B + 32'h10, 32'hDEADBEEF, 1, 32'h0, 0);
    req("lw10", 0, 2'b10, 0, B + 32'h10, 32'h0, 1, 32'hDEADBEEF, 0);
    req("lb13", 0, 2'b00, 0, B + 32'h13, 32'h0, 1, 32'hFFFFFFDE, 0);
    req("lbu13", 0, 2'b00, 1, B + 32'h13, 32'h0, 1, 32'h000000DE, 0);
    req("lh12", 0, 2'b01, 0, B + 32'h12, 32'h0, 1, 32'hFFFFDEAD, 0);
    req("lhu12", 0, 2'b01, 1, B + 32'h12, 32'h0, 1, 32'h0000DEAD, 0);

    // Back-to-back SB then LW with valid held high
    i_we = 1'b1; i_size = 2'b00; i_unsigned = 1'b0; i_address = B + 32'h11; i_wdata = 32'h55;
    i_req_valid = 1'b1;
    chk("b2b:ready0", 32'(o_req_ready), 32'd1);
    @(posedge clk);
    #1 i_we = 1'b0; i_size = 2'b10; i_address = B + 32'h10; i_wdata = 32'h0;
    @(negedge clk);
    chk("b2b:ready1", 32'(o_req_ready), 32'd1);
    chk("b2b:sb_rsp", 32'(o_rsp_valid), 32'd1);
    chk("b2b:sb_rdata", o_rdata, 32'h0);
    chk("b2b:sb_err", 32'(o_err), 32'd0);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(negedge clk);
    chk("b2b:lw_rsp", 32'(o_rsp_valid), 32'd1);
    chk("b2b:lw_rdata", o_rdata, 32'hDEAD55EF);
    chk("b2b:lw_err", 32'(o_err), 32'd0);
    @(negedge clk);
    chk("b2b:pulse", 32'(o_rsp_valid), 32'd0);

    req("sw14", 1, 2'b10, 0, B + 32'h14, 32'h11223344, 1, 32'h0, 0);
    req("sw18", 1, 2'b10, 0, B + 32'h18, 32'h99887766, 1, 32'h0, 0);
`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    req("lw12", 0, 2'b10, 0, B + 32'h12, 32'h0, 2, 32'h3344DEAD, 0);
    req("lh11", 0, 2'b01, 0, B + 32'h11, 32'h0, 2, 32'hFFFFAD55, 0);
`else
    req("lw12", 0, 2'b10, 0, B + 32'h12, 32'h0, 1, 32'h0, 1);
    req("lh11", 0, 2'b01, 0, B + 32'h11, 32'h0, 1, 32'h0, 1);
`endif
    req("size11", 0, 2'b11, 0, B + 32'h10, 32'h0, 1, 32'h0, 1);

    // Range boundaries around the last word
    req("swlast", 1, 2'b10, 0, TOP - 32'h4, 32'hCAFEF00D, 1, 32'h0, 0);
    req("lwlow", 0, 2'b10, 0, B - 32'h4, 32'h0, 1, 32'h0, 1);
    req("swtop", 1, 2'b10, 0, TOP, 32'h12345678, 1, 32'h0, 1);
    req("swcross", 1, 2'b10, 0, TOP - 32'h2, 32'h87654321, 1, 32'h0, 1);
    req("lhucross", 0, 2'b01, 1, TOP - 32'h1, 32'h0, 1, 32'h0, 1);
    req("lwlast", 0, 2'b10, 0, TOP - 32'h4, 32'h0, 1, 32'hCAFEF00D, 0);
    req("lhlast", 0, 2'b01, 0, TOP - 32'h2, 32'h0, 1, 32'hFFFFCAFE, 0);

`ifdef DATA_MEM_MISALIGN_SPLIT_EN
    // Reset lands in the SPLIT cycle of a misaligned store
    i_we = 1'b1; i_size = 2'b10; i_unsigned = 1'b0; i_address = B + 32'h16;
    i_wdata = 32'hAABBCCDD; i_req_valid = 1'b1;
    chk("rstsplit:ready", 32'(o_req_ready), 32'd1);
    @(posedge clk);
    #1 i_req_valid = 1'b0; i_rst = 1'b1;
    @(negedge clk);
    chk("rstsplit:rsp0", 32'(o_rsp_valid), 32'd0);
    chk("rstsplit:ready_rst", 32'(o_req_ready), 32'd0);
    @(negedge clk);
    chk("rstsplit:rsp1", 32'(o_rsp_valid), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rstsplit:rsp2", 32'(o_rsp_valid), 32'd0);
    chk("rstsplit:ready_after", 32'(o_req_ready), 32'd1);
    req("rstsplit_lw14", 0, 2'b10, 0, B + 32'h14, 32'h0, 1, 32'hCCDD3344, 0);
    req("rstsplit_lw18", 0, 2'b10, 0, B + 32'h18, 32'h0, 1, 32'h99887766, 0);
    req("sw1a", 1, 2'b10, 0, B + 32'h1A, 32'h01020304, 2, 32'h0, 0);
    req("lw18b", 0, 2'b10, 0, B + 32'h18, 32'h0, 1, 32'h03047766, 0);
    req("lhu1c", 0, 2'b01, 1, B + 32'h1C, 32'h0, 1, 32'h00000102, 0);
`else
    req("sw16", 1, 2'b10, 0, B + 32'h16, 32'hAABBCCDD, 1, 32'h0, 1);
    req("lw14b", 0, 2'b10, 0, B + 32'h14, 32'h0, 1, 32'h11223344, 0);
    req("lw18b", 0, 2'b10, 0, B + 32'h18, 32'h0, 1, 32'h99887766, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
